// File: rtl/debug_pkg.sv
// Debug controller command opcodes and per-opcode frame/response helpers.
package debug_pkg;

    typedef enum logic [3:0] {
        PAUSE     = 4'd0,
        RESUME    = 4'd1,
        STEP      = 4'd2,
        RESET     = 4'd3,
        STATUS    = 4'd4,
        BR_PT_ADD = 4'd5,
        BR_PT_RM  = 4'd6,
        MEM_RD    = 4'd7,
        MEM_WR    = 4'd8,
        REG_RD    = 4'd9,
        REG_WR    = 4'd10
    } DEBUG_FN;

    localparam logic [3:0] FN_MAX = 4'd10;

    // Opcode is followed by a 4-byte address.
    function automatic logic fn_has_addr(input logic [3:0] fn);
        case (fn)
            BR_PT_ADD, BR_PT_RM, MEM_RD, MEM_WR, REG_RD, REG_WR: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

    // Opcode is followed by 4 bytes of write data (after the address).
    function automatic logic fn_has_data(input logic [3:0] fn);
        case (fn)
            MEM_WR, REG_WR: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    // Opcode returns 4 bytes of read data instead of a single ack byte.
    function automatic logic fn_has_rdata(input logic [3:0] fn);
        case (fn)
            STATUS, MEM_RD, REG_RD: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/serial_cmd_decoder.sv
// UART-to-debug-controller command decoder: frames host bytes into commands,
// hands them off with a valid/busy handshake and streams back the response.
// Optional build macro: CMD_TIMEOUT_EN enables the inter-byte idle timeout.
module serial_cmd_decoder
    import debug_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  ACK_BYTE       = 8'hAA,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [3:0]  debug_fn,
    output logic [31:0] addr,
    output logic [31:0] d_in,
    output logic        out_valid,
    input  logic        ctrlr_busy,
    input  logic [31:0] d_rd,
    output logic        rx_overrun
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] ST_OP     = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    logic [2:0]        state_q, state_n;
    logic [1:0]        cnt_q, cnt_n;
    logic [WORD_W-1:0] rdata_q, rdata_n;
    logic              multi_q, multi_n;
    logic [3:0]        fn_n;
    logic [WORD_W-1:0] addr_n, din_n;
    logic [BYTE_W-1:0] tx_data_n;
    logic              tx_valid_n, out_valid_n, overrun_n;
    logic              tmo_hit_c;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TMO_W = 32;
    logic [TMO_W-1:0] tmo_q, tmo_n;

    // Idle counter runs only while a frame is partially received.
    always_comb begin
        tmo_n = '0;
        if (!rx_valid && (state_q == ST_ADDR || state_q == ST_DATA))
            tmo_n = tmo_q + TMO_W'(1);
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_n;
    end

    assign tmo_hit_c = !rx_valid && (state_q == ST_ADDR || state_q == ST_DATA)
                       && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign tmo_hit_c          = 1'b0;
`endif

    // Next-state and next-output logic for the frame/issue/response sequence.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        rdata_n     = rdata_q;
        multi_n     = multi_q;
        fn_n        = debug_fn;
        addr_n      = addr;
        din_n       = d_in;
        tx_data_n   = tx_data;
        tx_valid_n  = tx_valid;
        out_valid_n = out_valid;
        overrun_n   = rx_overrun;

        case (state_q)
            ST_OP: begin
                if (rx_valid) begin
                    fn_n  = rx_data[3:0];
                    cnt_n = 2'd0;
                    if (rx_data > {4'd0, FN_MAX}) begin
                        state_n    = ST_RESP;
                        tx_valid_n = 1'b1;
                        tx_data_n  = ERR_BYTE;
                        multi_n    = 1'b0;
                    end else if (fn_has_addr(rx_data[3:0])) begin
                        state_n = ST_ADDR;
                    end else begin
                        state_n     = ST_ISSUE;
                        out_valid_n = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (tmo_hit_c) begin
                    state_n = ST_OP;
                    cnt_n   = 2'd0;
                end else if (rx_valid) begin
                    addr_n = {addr[WORD_W-BYTE_W-1:0], rx_data};
                    cnt_n  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (fn_has_data(debug_fn)) begin
                            state_n = ST_DATA;
                        end else begin
                            state_n     = ST_ISSUE;
                            out_valid_n = 1'b1;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (tmo_hit_c) begin
                    state_n = ST_OP;
                    cnt_n   = 2'd0;
                end else if (rx_valid) begin
                    din_n = {d_in[WORD_W-BYTE_W-1:0], rx_data};
                    cnt_n = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_n     = ST_ISSUE;
                        out_valid_n = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (ctrlr_busy) begin
                    state_n     = ST_WAIT;
                    out_valid_n = 1'b0;
                end
            end
            ST_WAIT: begin
                if (!ctrlr_busy) begin
                    state_n    = ST_RESP;
                    rdata_n    = d_rd;
                    cnt_n      = 2'd0;
                    multi_n    = fn_has_rdata(debug_fn);
                    tx_valid_n = 1'b1;
                    tx_data_n  = fn_has_rdata(debug_fn) ? d_rd[WORD_W-1 -: BYTE_W] : ACK_BYTE;
                end
            end
            ST_RESP: begin
                if (tx_valid && tx_ready) begin
                    if (multi_q && cnt_q != 2'd3) begin
                        cnt_n     = cnt_q + 2'd1;
                        rdata_n   = rdata_q << BYTE_W;
                        tx_data_n = rdata_q[WORD_W-BYTE_W-1 -: BYTE_W];
                    end else begin
                        state_n    = ST_OP;
                        cnt_n      = 2'd0;
                        tx_valid_n = 1'b0;
                    end
                end
            end
            default: state_n = ST_OP;
        endcase

        // Bytes arriving outside the receive states are dropped and flagged.
        if (rx_valid && (state_q == ST_ISSUE || state_q == ST_WAIT || state_q == ST_RESP))
            overrun_n = 1'b1;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OP;
            cnt_q      <= 2'd0;
            rdata_q    <= '0;
            multi_q    <= 1'b0;
            debug_fn   <= 4'd0;
            addr       <= '0;
            d_in       <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            out_valid  <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            rdata_q    <= rdata_n;
            multi_q    <= multi_n;
            debug_fn   <= fn_n;
            addr       <= addr_n;
            d_in       <= din_n;
            tx_data    <= tx_data_n;
            tx_valid   <= tx_valid_n;
            out_valid  <= out_valid_n;
            rx_overrun <= overrun_n;
        end
    end

endmodule
